// File: rtl/writeback_arbiter_if.sv
// Writeback arbiter bus: two write sources, downstream stall and the registered write port.
interface writeback_arbiter_if #(
    parameter int N = 8,
    parameter int R = 2
);
    logic         valid1;
    logic         valid2;
    logic [R-1:0] addr1;
    logic [R-1:0] addr2;
    logic [N-1:0] in1;
    logic [N-1:0] in2;
    logic         ready1;
    logic         ready2;
    logic         hold;
    logic         control;
    logic         wb_en;
    logic [R-1:0] wb_addr;
    logic [N-1:0] wb_data;
    logic [7:0]   conflict_count;

    modport master (
        output valid1, valid2, addr1, addr2, in1, in2, hold,
        input  ready1, ready2, control, wb_en, wb_addr, wb_data, conflict_count
    );

    modport slave (
        input  valid1, valid2, addr1, addr2, in1, in2, hold,
        output ready1, ready2, control, wb_en, wb_addr, wb_data, conflict_count
    );
endinterface

// File: rtl/writeback_arbiter.sv
// Two-source register-file writeback arbiter; WB_ROUND_ROBIN_EN selects round-robin, else source 1 wins.
// Latency: 1 cycle from accepted request to wb_en/wb_addr/wb_data/control.
// Backpressure: hold freezes the output stage and drops both readies; the loser of a conflict waits.
module writeback_arbiter #(
    parameter int N = 8,
    parameter int R = 2
) (
    input logic                clock,
    input logic                reset,
    writeback_arbiter_if.slave bus
);
    typedef enum logic {IDLE = 1'b0, WRITE = 1'b1} state_t;

    state_t       state;
    state_t       state_nxt;
    logic [R-1:0] wb_addr_q;
    logic [N-1:0] wb_data_q;
    logic         control_q;
    logic [7:0]   conflict_q;
    logic         conflict;
    logic         pick2;
    logic         ready1;
    logic         ready2;
    logic         xfer;

    assign conflict = bus.valid1 && bus.valid2;

`ifdef WB_ROUND_ROBIN_EN
    // last_is2 = 1 means source 2 was granted last, so a conflict goes to source 1.
    logic last_is2;

    always_ff @(posedge clock) begin
        if (reset) begin
            last_is2 <= 1'b1;
        end else if (xfer) begin
            last_is2 <= ready2;
        end
    end

    assign pick2 = bus.valid2 && (!bus.valid1 || !last_is2);
`else
    assign pick2 = bus.valid2 && !bus.valid1;
`endif

    assign ready1 = !reset && !bus.hold && bus.valid1 && !pick2;
    assign ready2 = !reset && !bus.hold && pick2;
    assign xfer   = ready1 || ready2;

    always_comb begin
        state_nxt = state;
        if (!bus.hold) begin
            state_nxt = xfer ? WRITE : IDLE;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            wb_addr_q  <= '0;
            wb_data_q  <= '0;
            control_q  <= 1'b0;
            conflict_q <= 8'd0;
        end else begin
            state <= state_nxt;
            if (xfer) begin
                wb_addr_q <= ready2 ? bus.addr2 : bus.addr1;
                wb_data_q <= ready2 ? bus.in2 : bus.in1;
                control_q <= ready2;
            end
            if (conflict && !bus.hold && conflict_q != 8'd255) begin
                conflict_q <= conflict_q + 8'd1;
            end
        end
    end

    assign bus.ready1         = ready1;
    assign bus.ready2         = ready2;
    assign bus.wb_en          = (state == WRITE);
    assign bus.wb_addr        = wb_addr_q;
    assign bus.wb_data        = wb_data_q;
    assign bus.control        = control_q;
    assign bus.conflict_count = conflict_q;
endmodule
